// File: rtl/alu_result_serializer_pkg.sv
// Shared definitions for the ALU result serializer.
// Holds the output FSM state encoding and the default result/byte widths
// so the top level and the result buffer agree on them.
package alu_result_serializer_pkg;

  localparam int DEF_RES_WIDTH  = 16;
  localparam int DEF_BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_FIRST  = 2'd1,
    SEND_SECOND = 2'd2
  } tx_state_t;

endpackage

// File: rtl/alu_result_serializer_res_fifo.sv
// res_fifo: synchronous DEPTH x WIDTH result buffer, pointers wrap modulo DEPTH.
// Latency: a pushed entry is visible at head_data on the cycle after the push.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
module res_fifo
  import alu_result_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_RES_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [WIDTH-1:0]         next_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_nxt;
  logic             do_push;
  logic             do_pop;

  // Full + pop frees the head slot in the same cycle, so the push may reuse it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rd_nxt    = rd_ptr + 1'b1;
  assign head_data = mem[rd_ptr];
  assign next_data = mem[rd_nxt];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

  // Storage array; left unreset so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_serializer.sv
// Serializes buffered ALU results into two bytes each over a valid/ready port.
// Latency: a result pushed into an empty block is offered as a byte next cycle.
// Backpressure: none toward the ALU; results arriving at a full buffer are dropped (OVF).
module alu_result_serializer
  import alu_result_serializer_pkg::*;
#(
  parameter int RES_WIDTH  = DEF_RES_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
  parameter int DEPTH      = 4,
  parameter int LSB_FIRST  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [RES_WIDTH-1:0]  RES_DATA,
  input  logic                  RES_VALID,
  output logic [BYTE_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  BUF_FULL,
  output logic                  BUF_EMPTY,
  output logic                  OVF
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  tx_state_t            state;
  logic [RES_WIDTH-1:0] head_data;
  logic [RES_WIDTH-1:0] next_data;
  logic [RES_WIDTH-1:0] start_data;
  logic [CW-1:0]        count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 push;
  logic                 start;

  function automatic logic [BYTE_WIDTH-1:0] first_byte(input logic [RES_WIDTH-1:0] r);
    first_byte = (LSB_FIRST != 0) ? r[BYTE_WIDTH-1:0] : r[2*BYTE_WIDTH-1:BYTE_WIDTH];
  endfunction

  function automatic logic [BYTE_WIDTH-1:0] second_byte(input logic [RES_WIDTH-1:0] r);
    second_byte = (LSB_FIRST != 0) ? r[2*BYTE_WIDTH-1:BYTE_WIDTH] : r[BYTE_WIDTH-1:0];
  endfunction

  // The head leaves the buffer only once its second byte is accepted.
  assign pop  = TX_VALID && TX_READY && (state == SEND_SECOND);
  assign push = RES_VALID && (!fifo_full || pop);

  assign BUF_FULL  = fifo_full;
  assign BUF_EMPTY = fifo_empty && (state == IDLE);

  res_fifo #(
    .WIDTH (RES_WIDTH),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data (RES_DATA),
    .pop       (pop),
    .head_data (head_data),
    .next_data (next_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  // Pick the result whose first byte goes out next; a result arriving this
  // cycle is bypassed straight to the byte register when nothing older is queued.
  always_comb begin
    start      = 1'b0;
    start_data = head_data;
    case (state)
      IDLE: begin
        start      = push || !fifo_empty;
        start_data = fifo_empty ? RES_DATA : head_data;
      end
      SEND_SECOND: begin
        start      = (count > CNT_ONE) || push;
        start_data = (count > CNT_ONE) ? next_data : RES_DATA;
      end
      default: begin
        start      = 1'b0;
        start_data = head_data;
      end
    endcase
  end

  // Output FSM with registered byte, valid and overflow pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      TX_VALID <= 1'b0;
      TX_DATA  <= '0;
      OVF      <= 1'b0;
    end else begin
      OVF <= RES_VALID && !push;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SEND_FIRST;
            TX_VALID <= 1'b1;
            TX_DATA  <= first_byte(start_data);
          end
        end
        SEND_FIRST: begin
          if (TX_READY) begin
            state   <= SEND_SECOND;
            TX_DATA <= second_byte(head_data);
          end
        end
        SEND_SECOND: begin
          if (TX_READY) begin
            if (start) begin
              state   <= SEND_FIRST;
              TX_DATA <= first_byte(start_data);
            end else begin
              state    <= IDLE;
              TX_VALID <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          TX_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Self-checking bench for alu_result_serializer (default parameters, LSB first).
// A queue of not-yet-finished results plus a byte phase models the block.
// Directed scenarios are followed by a randomized run compared cycle by cycle.
module tb_alu_result_serializer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] RES_DATA = '0;
  logic        RES_VALID = 1'b0;
  logic        TX_READY = 1'b0;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        BUF_FULL;
  logic        BUF_EMPTY;
  logic        OVF;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: results accepted but not fully sent, head byte phase, drop pulse.
  logic [15:0] mq [$];
  bit          m_phase;
  bit          m_ovf;
  logic [7:0]  obs [$];

  alu_result_serializer #(
    .RES_WIDTH  (16),
    .BYTE_WIDTH (8),
    .DEPTH      (DEPTH),
    .LSB_FIRST  (1)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RES_DATA  (RES_DATA),
    .RES_VALID (RES_VALID),
    .TX_DATA   (TX_DATA),
    .TX_VALID  (TX_VALID),
    .TX_READY  (TX_READY),
    .BUF_FULL  (BUF_FULL),
    .BUF_EMPTY (BUF_EMPTY),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] exp_byte();
    logic [15:0] h;
    h = mq[0];
    return m_phase ? h[15:8] : h[7:0];
  endfunction

  // One clock: log accepted bytes before the edge, advance the model at the
  // edge, return 1 time unit later so outputs have settled.
  task automatic tick();
    bit hs;
    bit pop;
    bit ok;
    @(negedge CLK);
    if (TX_VALID && TX_READY && !RST) obs.push_back(TX_DATA);
    @(posedge CLK);
    if (RST) begin
      mq.delete();
      m_phase = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      hs  = (mq.size() > 0) && TX_READY;
      pop = hs && m_phase;
      ok  = RES_VALID && ((mq.size() < DEPTH) || pop);
      m_ovf = RES_VALID && !ok;
      if (hs)  m_phase = !m_phase;
      if (pop) void'(mq.pop_front());
      if (ok)  mq.push_back(RES_DATA);
    end
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    n_checks++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", TX_VALID); end
    n_checks++; if (TX_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", TX_DATA); end
    n_checks++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", OVF); end
    n_checks++; if (BUF_FULL !== 1'b0) begin n_fail++; $display("FAIL reset_buf_full: got %b want 0", BUF_FULL); end
    n_checks++; if (BUF_EMPTY !== 1'b1) begin n_fail++; $display("FAIL reset_buf_empty: got %b want 1", BUF_EMPTY); end
    RST = 1'b0;
  endtask

  // Push on the very first edge after reset release; bytes in N+1, N+2.
  task automatic test_single();
    TX_READY  = 1'b1;
    RES_VALID = 1'b1;
    RES_DATA  = 16'hA55A;
    tick();
    RES_VALID = 1'b0;
    n_checks++; if (TX_VALID !== 1'b1) begin n_fail++; $display("FAIL single_valid1: got %b want 1", TX_VALID); end
    n_checks++; if (TX_DATA !== 8'h5A) begin n_fail++; $display("FAIL single_byte1: got %h want 5a", TX_DATA); end
    tick();
    n_checks++; if (TX_VALID !== 1'b1) begin n_fail++; $display("FAIL single_valid2: got %b want 1", TX_VALID); end
    n_checks++; if (TX_DATA !== 8'hA5) begin n_fail++; $display("FAIL single_byte2: got %h want a5", TX_DATA); end
    tick();
    n_checks++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL single_done_valid: got %b want 0", TX_VALID); end
    n_checks++; if (BUF_EMPTY !== 1'b1) begin n_fail++; $display("FAIL single_done_empty: got %b want 1", BUF_EMPTY); end
  endtask

  // Byte held stable under backpressure.
  task automatic test_stall();
    TX_READY  = 1'b0;
    RES_VALID = 1'b1;
    RES_DATA  = 16'h1234;
    tick();
    RES_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (TX_VALID !== 1'b1 || TX_DATA !== 8'h34) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%b d=%h want v=1 d=34", i, TX_VALID, TX_DATA);
      end
      if (i < 4) tick();
    end
    TX_READY = 1'b1;
    tick();
    n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h12) begin n_fail++; $display("FAIL stall_second: got v=%b d=%h want v=1 d=12", TX_VALID, TX_DATA); end
    tick();
    n_checks++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL stall_done: got %b want 0", TX_VALID); end
  endtask

  // Two results pushed back-to-back stream four bytes with no gap.
  task automatic test_back_to_back();
    logic [15:0] r1;
    logic [15:0] r2;
    logic [7:0]  exp [4];
    r1 = 16'($urandom);
    r2 = 16'($urandom);
    exp[0] = r1[7:0]; exp[1] = r1[15:8]; exp[2] = r2[7:0]; exp[3] = r2[15:8];
    TX_READY  = 1'b1;
    RES_VALID = 1'b1;
    RES_DATA  = r1;
    tick();
    RES_DATA  = r2;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (TX_VALID !== 1'b1 || TX_DATA !== exp[i]) begin
        n_fail++; $display("FAIL b2b_byte[%0d]: got v=%b d=%h want v=1 d=%h", i, TX_VALID, TX_DATA, exp[i]);
      end
      tick();
      RES_VALID = 1'b0;
    end
    n_checks++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL b2b_done: got %b want 0", TX_VALID); end
  endtask

  // Five pushes into a stalled DEPTH=4 buffer: one drop, first four survive.
  task automatic test_overflow();
    TX_READY = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      RES_VALID = 1'b1;
      RES_DATA  = 16'(k);
      tick();
      if (k == 4) begin
        n_checks++; if (BUF_FULL !== 1'b1) begin n_fail++; $display("FAIL ovf_full_after4: got %b want 1", BUF_FULL); end
        n_checks++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", OVF); end
      end
    end
    RES_VALID = 1'b0;
    n_checks++; if (OVF !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b want 1", OVF); end
    tick();
    n_checks++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL ovf_single_pulse: got %b want 0", OVF); end
    obs.delete();
    TX_READY = 1'b1;
    for (int i = 0; i < 40 && BUF_EMPTY !== 1'b1; i++) tick();
    n_checks++; if (BUF_EMPTY !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_timeout: got empty=%b want 1", BUF_EMPTY); end
    n_checks++; if (obs.size() != 8) begin n_fail++; $display("FAIL ovf_drain_count: got %0d bytes want 8", obs.size()); end
    for (int i = 0; i < 8 && i < obs.size(); i++) begin
      logic [7:0] want;
      want = (i % 2 == 0) ? 8'(i / 2 + 1) : 8'h00;
      n_checks++;
      if (obs[i] !== want) begin n_fail++; $display("FAIL ovf_drain_byte[%0d]: got %h want %h", i, obs[i], want); end
    end
  endtask

  // Full buffer with a push landing on the head's final handshake.
  task automatic test_full_pop_push();
    logic [7:0] want [8];
    want = '{8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'hEF, 8'hBE};
    TX_READY = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      RES_VALID = 1'b1;
      RES_DATA  = {8'(k * 8'h11), 8'(k * 8'h11)};
      tick();
    end
    RES_VALID = 1'b0;
    n_checks++; if (BUF_FULL !== 1'b1) begin n_fail++; $display("FAIL fpp_full: got %b want 1", BUF_FULL); end
    TX_READY = 1'b1;
    tick();
    RES_VALID = 1'b1;
    RES_DATA  = 16'hBEEF;
    tick();
    RES_VALID = 1'b0;
    obs.delete();
    n_checks++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL fpp_no_ovf: got %b want 0", OVF); end
    n_checks++; if (BUF_FULL !== 1'b1) begin n_fail++; $display("FAIL fpp_still_full: got %b want 1", BUF_FULL); end
    n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h22) begin n_fail++; $display("FAIL fpp_next_byte: got v=%b d=%h want v=1 d=22", TX_VALID, TX_DATA); end
    for (int i = 0; i < 40 && BUF_EMPTY !== 1'b1; i++) tick();
    n_checks++; if (obs.size() != 8) begin n_fail++; $display("FAIL fpp_drain_count: got %0d bytes want 8", obs.size()); end
    for (int i = 0; i < 8 && i < obs.size(); i++) begin
      n_checks++;
      if (obs[i] !== want[i]) begin n_fail++; $display("FAIL fpp_drain_byte[%0d]: got %h want %h", i, obs[i], want[i]); end
    end
  endtask

  // Reset in SEND_SECOND with two results queued discards everything.
  task automatic test_reset_mid();
    TX_READY  = 1'b0;
    RES_VALID = 1'b1;
    RES_DATA  = 16'hC3D2;
    tick();
    RES_DATA  = 16'h7788;
    tick();
    RES_VALID = 1'b0;
    TX_READY  = 1'b1;
    tick();
    n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'hC3) begin n_fail++; $display("FAIL rmid_pre: got v=%b d=%h want v=1 d=c3", TX_VALID, TX_DATA); end
    RST = 1'b1;
    #1;
    n_checks++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", TX_VALID); end
    n_checks++; if (BUF_EMPTY !== 1'b1) begin n_fail++; $display("FAIL rmid_empty: got %b want 1", BUF_EMPTY); end
    n_checks++; if (TX_DATA !== 8'h00) begin n_fail++; $display("FAIL rmid_data: got %h want 00", TX_DATA); end
    tick();
    RST = 1'b0;
    obs.delete();
    repeat (5) tick();
    n_checks++; if (obs.size() != 0 || TX_VALID !== 1'b0) begin n_fail++; $display("FAIL rmid_no_resend: got %0d bytes v=%b want 0 bytes v=0", obs.size(), TX_VALID); end
    RES_VALID = 1'b1;
    RES_DATA  = 16'h5566;
    tick();
    RES_VALID = 1'b0;
    n_checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h66) begin n_fail++; $display("FAIL rmid_new: got v=%b d=%h want v=1 d=66", TX_VALID, TX_DATA); end
    for (int i = 0; i < 40 && BUF_EMPTY !== 1'b1; i++) tick();
  endtask

  // Random traffic and backpressure against the queue model.
  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      int push_pct;
      int rdy_pct;
      push_pct = (c < 400) ? 40 : 75;
      rdy_pct  = (c < 200) ? 90 : ((c < 600) ? 50 : 25);
      RES_VALID = ($urandom_range(0, 99) < push_pct);
      RES_DATA  = 16'($urandom);
      TX_READY  = ($urandom_range(0, 99) < rdy_pct);
      tick();
      n_checks++; if (TX_VALID !== (mq.size() > 0)) begin n_fail++; $display("FAIL rand_valid@%0d: got %b want %b", c, TX_VALID, mq.size() > 0); end
      if (mq.size() > 0) begin
        n_checks++; if (TX_DATA !== exp_byte()) begin n_fail++; $display("FAIL rand_data@%0d: got %h want %h", c, TX_DATA, exp_byte()); end
      end
      n_checks++; if (BUF_FULL !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL rand_full@%0d: got %b want %b", c, BUF_FULL, mq.size() == DEPTH); end
      n_checks++; if (BUF_EMPTY !== (mq.size() == 0)) begin n_fail++; $display("FAIL rand_empty@%0d: got %b want %b", c, BUF_EMPTY, mq.size() == 0); end
      n_checks++; if (OVF !== m_ovf) begin n_fail++; $display("FAIL rand_ovf@%0d: got %b want %b", c, OVF, m_ovf); end
    end
    RES_VALID = 1'b0;
    TX_READY  = 1'b1;
    for (int i = 0; i < 40 && BUF_EMPTY !== 1'b1; i++) tick();
    n_checks++; if (BUF_EMPTY !== 1'b1) begin n_fail++; $display("FAIL rand_final_drain: got %b want 1", BUF_EMPTY); end
  endtask

  initial begin
    mq.delete();
    m_phase = 1'b0;
    m_ovf   = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_full_pop_push();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_serializer.md
ALU_RESULT_SERIALIZER -- requirements
Module: alu_result_serializer

Interface
REQ-001 Parameters SHALL be: RES_WIDTH, 16, width of one ALU result; BYTE_WIDTH, 8, width of one output byte; DEPTH, 4, result buffer entries (power of two, >=2); LSB_FIRST, 1, 1 = low byte sent first, 0 = high byte first.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 RES_DATA  input  RES_WIDTH  ALU result to be serialized.
REQ-005 RES_VALID  input  1  RES_DATA valid this cycle; one result per high cycle.
REQ-006 TX_DATA  output  BYTE_WIDTH  byte offered downstream.
REQ-007 TX_VALID  output  1  TX_DATA valid.
REQ-008 TX_READY  input  1  downstream accepts TX_DATA when TX_VALID and TX_READY are both high.
REQ-009 BUF_FULL  output  1  buffer holds DEPTH results.
REQ-010 BUF_EMPTY  output  1  buffer holds no results and no byte in flight.
REQ-011 OVF  output  1  one-cycle pulse: a result was dropped.

Function
REQ-012 Block SHALL have no ready toward the ALU; every RES_VALID cycle is a push attempt.
REQ-013 Push SHALL succeed when buffer not full, or when full and the head result completes its final byte handshake in the same cycle.
REQ-014 Failed push SHALL discard RES_DATA, leave buffer unchanged, and pulse OVF in the following cycle.
REQ-015 Output FSM states SHALL be IDLE, SEND_FIRST, SEND_SECOND.
REQ-016 IDLE -> SEND_FIRST when buffer non-empty; SEND_FIRST -> SEND_SECOND on handshake; SEND_SECOND -> SEND_FIRST on handshake if another result remains after pop, else -> IDLE.
REQ-017 Head result SHALL be popped only on the SEND_SECOND handshake.
REQ-018 TX_VALID SHALL be high exactly in SEND_FIRST and SEND_SECOND.
REQ-019 With LSB_FIRST=1, SEND_FIRST drives RES_DATA[7:0] and SEND_SECOND drives RES_DATA[15:8] of the head; reversed for LSB_FIRST=0.
REQ-020 TX_DATA and TX_VALID SHALL be register outputs and stay stable while TX_VALID high and TX_READY low.
REQ-021 Latency: push into empty buffer in cycle N SHALL give TX_VALID high with first byte in cycle N+1.
REQ-022 With TX_READY held high, one result SHALL drain in 2 cycles; back-to-back results SHALL produce bytes every cycle with no idle gap.
REQ-023 Occupancy counter SHALL be $clog2(DEPTH)+1 bits; read/write pointers SHALL wrap modulo DEPTH.
REQ-024 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-025 BUF_FULL SHALL equal (count==DEPTH); BUF_EMPTY SHALL equal (count==0 and state IDLE).

Reset
REQ-026 Asserting RST SHALL at once force: state IDLE, count 0, pointers 0, TX_VALID 0, TX_DATA 0, OVF 0, BUF_FULL 0, BUF_EMPTY 1.
REQ-027 RST mid-transfer SHALL discard buffered results and any partially sent result; no byte is resent after release.
REQ-028 First push SHALL be accepted on the first rising edge with RST low.

Structure
REQ-029 Shared package SHALL hold FSM state encoding and default RES_WIDTH/BYTE_WIDTH constants.
REQ-030 Buffer SHALL be sub-module res_fifo (synchronous, DEPTH x RES_WIDTH, push/pop/full/empty/count); FSM and byte mux stay in top.

Verification
REQ-031 Single result 16'hA55A, TX_READY=1, LSB_FIRST=1 -> bytes 8'h5A then 8'hA5 in cycles N+1, N+2; then BUF_EMPTY=1.
REQ-032 Result 16'h1234, TX_READY=0 for 5 cycles then 1 -> TX_DATA=8'h34 stable 5 cycles, then 8'h12, then TX_VALID=0.
REQ-033 TX_READY=0, push 5 results 1..5 with DEPTH=4 -> BUF_FULL=1 after 4th, OVF pulse once for 5th; drain yields only results 1..4 in order.
REQ-034 Buffer full, push on same cycle as SEND_SECOND handshake -> push accepted, no OVF, count stays 4.
REQ-035 RST asserted while in SEND_SECOND with 2 results buffered -> TX_VALID=0 immediately, BUF_EMPTY=1, no bytes after release until new push.
